block_memory_word_port: RTL and testbench

//  Initiator side of the byte-wide dual-port block RAM: turns 32-bit CPU load/store requests
//  (byte/half/word, little-endian) into a serial sequence of 8-bit port-A accesses, one byte per

---
 rtl/block_memory_word_port_pkg.sv | 34 +++
 rtl/block_memory_16kbit.sv | 25 ++
 rtl/block_memory_load_extend.sv | 37 +++
 rtl/block_memory_word_port.sv | 145 ++++++++++++++
 tb/tb_block_memory_word_port.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/block_memory_word_port_pkg.sv
// Shared definitions for the block RAM word port: request size codes, FSM states, size helpers.
// The optional feature macro BLOCK_MEMORY_WORD_PORT_SIGN_EXTEND_EN is consumed in block_memory_load_extend.
package block_memory_word_port_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // Index of the final byte of an access (N-1 for N = 1 << size).
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SIZE_HALF: last_index = 2'd1;
            SIZE_WORD: last_index = 2'd3;
            default:   last_index = 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        case (size)
            SIZE_HALF: misaligned = addr_lsb[0];
            SIZE_WORD: misaligned = |addr_lsb;
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/block_memory_16kbit.sv
// Byte-wide dual-port block RAM, 2^address_width bytes: port A read/write, port B read-only.
// Both read ports are registered (data valid one cycle after the address).
module block_memory_16kbit #(
    parameter int address_width = 11
) (
    input  logic                     clk,
    input  logic [address_width-1:0] a_address,
    input  logic                     a_write_enable,
    input  logic [7:0]               a_write_data,
    output logic [7:0]               a_read_data,
    input  logic [address_width-1:0] b_address,
    output logic [7:0]               b_read_data
);

    logic [7:0] mem_q [0:(1 << address_width)-1];

    always_ff @(posedge clk) begin
        if (a_write_enable) begin
            mem_q[a_address] <= a_write_data;
        end
        a_read_data <= mem_q[a_address];
        b_read_data <= mem_q[b_address];
    end

endmodule

// File: rtl/block_memory_load_extend.sv
// Load result extension. With BLOCK_MEMORY_WORD_PORT_SIGN_EXTEND_EN defined, signed byte/half loads
// sign-extend; otherwise every load zero-extends and unsigned_i is ignored.
module block_memory_load_extend
    import block_memory_word_port_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);

`ifdef BLOCK_MEMORY_WORD_PORT_SIGN_EXTEND_EN
    always_comb begin
        ext_o = raw_i;
        case (size_i)
            SIZE_BYTE: ext_o = unsigned_i ? {24'h0, raw_i[7:0]}
                                          : {{24{raw_i[7]}}, raw_i[7:0]};
            SIZE_HALF: ext_o = unsigned_i ? {16'h0, raw_i[15:0]}
                                          : {{16{raw_i[15]}}, raw_i[15:0]};
            default:   ext_o = raw_i;
        endcase
    end
`else
    logic unused_unsigned;
    assign unused_unsigned = unsigned_i;

    always_comb begin
        ext_o = raw_i;
        case (size_i)
            SIZE_BYTE: ext_o = {24'h0, raw_i[7:0]};
            SIZE_HALF: ext_o = {16'h0, raw_i[15:0]};
            default:   ext_o = raw_i;
        endcase
    end
`endif

endmodule

// File: rtl/block_memory_word_port.sv
// Serialises 32-bit byte/half/word loads and stores into one-byte-per-cycle RAM port A accesses.
// Optional feature macro: BLOCK_MEMORY_WORD_PORT_SIGN_EXTEND_EN (signed sub-word loads).
module block_memory_word_port
    import block_memory_word_port_pkg::*;
#(
    parameter int address_width = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [address_width-1:0] req_address,
    input  logic [1:0]               req_size,
    input  logic                     req_write,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_write_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_read_data,
    output logic                     resp_error,
    output logic [address_width-1:0] mem_address,
    output logic                     mem_write_enable,
    output logic [7:0]               mem_write_data,
    input  logic [7:0]               mem_read_data
);

    state_t                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [1:0]               size_q, size_d;
    logic                     write_q, write_d;
    logic                     unsigned_q, unsigned_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              asm_q, asm_d;
    logic [31:0]              resp_data_q, resp_data_d;
    logic                     resp_error_q, resp_error_d;

    logic [1:0]  cap_idx;
    logic [31:0] asm_merge;
    logic [31:0] asm_ext;
    logic        req_bad;

    // Read data lags the issue by one cycle, so ACCESS captures the previous byte and DRAIN the last.
    assign cap_idx = (state_q == ST_DRAIN) ? cnt_q : cnt_q - 2'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign asm_merge[8*gi +: 8] = (cap_idx == 2'(gi)) ? mem_read_data : asm_q[8*gi +: 8];
        end
    endgenerate

    block_memory_load_extend u_extend (
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .raw_i      (asm_merge),
        .ext_o      (asm_ext)
    );

    assign req_bad = (req_size == SIZE_ILLEGAL) || misaligned(req_size, req_address[1:0]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d       = req_address;
                    size_d       = req_size;
                    write_d      = req_write;
                    unsigned_d   = req_unsigned;
                    wdata_d      = req_write_data;
                    cnt_d        = 2'd0;
                    asm_d        = 32'h0;
                    resp_data_d  = 32'h0;
                    resp_error_d = req_bad;
                    state_d      = req_bad ? ST_RESPOND : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!write_q && (cnt_q != 2'd0)) begin
                    asm_d = asm_merge;
                end
                if (cnt_q == last_index(size_q)) begin
                    state_d = write_q ? ST_RESPOND : ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                asm_d       = asm_merge;
                resp_data_d = asm_ext;
                state_d     = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            size_q       <= SIZE_BYTE;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= 32'h0;
            asm_q        <= 32'h0;
            resp_data_q  <= 32'h0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = (state_q == ST_RESPOND);
    assign resp_read_data   = resp_data_q;
    assign resp_error       = resp_error_q;
    assign mem_address      = addr_q + {{(address_width-2){1'b0}}, cnt_q};
    assign mem_write_enable = (state_q == ST_ACCESS) && write_q;
    assign mem_write_data   = wdata_q[8*cnt_q +: 8];

endmodule

// File: tb/tb_block_memory_word_port.sv
// Directed bench for block_memory_word_port driving a real block_memory_16kbit on port A;
// RAM contents are inspected through port B.
module tb_block_memory_word_port;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_address;
    logic [1:0]    req_size;
    logic          req_write;
    logic          req_unsigned;
    logic [31:0]   req_write_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_read_data;
    logic          resp_error;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic [7:0]    mem_write_data;
    logic [7:0]    mem_read_data;
    logic [AW-1:0] b_address;
    logic [7:0]    b_read_data;

    int checks_total  = 0;
    int checks_passed = 0;
    bit we_seen       = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable === 1'b1) we_seen = 1'b1;
    end

    block_memory_word_port #(.address_width(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_address      (req_address),
        .req_size         (req_size),
        .req_write        (req_write),
        .req_unsigned     (req_unsigned),
        .req_write_data   (req_write_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_read_data   (resp_read_data),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    block_memory_16kbit #(.address_width(AW)) u_ram (
        .clk            (clk),
        .a_address      (mem_address),
        .a_write_enable (mem_write_enable),
        .a_write_data   (mem_write_data),
        .a_read_data    (mem_read_data),
        .b_address      (b_address),
        .b_read_data    (b_read_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        else             checks_passed++;
    endtask

    // One request: waits for the handshake edge, drives the request, bounds the wait for resp_valid.
    task automatic transact(input logic [1:0] size, input logic [AW-1:0] addr, input bit wr,
                            input logic [31:0] wdata, input bit uns,
                            output logic [31:0] rdata, output logic err, output int lat);
        @(posedge clk); #1;
        req_size       = size;
        req_address    = addr;
        req_write      = wr;
        req_write_data = wdata;
        req_unsigned   = uns;
        req_valid      = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 20) check("resp_timeout", 32'(resp_valid), 32'd1);
        rdata = resp_read_data;
        err   = resp_error;
        $display("txn size=%0d addr=0x%03h wr=%0d wdata=0x%08h uns=%0d -> data=0x%08h err=%0d lat=%0d",
                 size, addr, wr, wdata, uns, rdata, err, lat);
    endtask

    task automatic ram_read(input logic [AW-1:0] addr, output logic [7:0] data);
        b_address = addr;
        @(posedge clk); #1;
        data = b_read_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [7:0]  rb;
        bit          rv_seen;
        logic [31:0] exp_signed;

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_address    = '0;
        req_size       = 2'd0;
        req_write      = 1'b0;
        req_unsigned   = 1'b0;
        req_write_data = 32'h0;
        resp_ready     = 1'b1;
        b_address      = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_req_ready",  32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_data",  resp_read_data, 32'h0);
        check("rst_mem_we",     32'(mem_write_enable), 32'd0);

        // 1: word store then word load
        transact(2'd2, 11'h010, 1'b1, 32'h11223344, 1'b0, rd, er, lat);
        check("st_word_lat", 32'(lat), 32'd5);
        check("st_word_err", 32'(er), 32'd0);
        check("st_word_data", rd, 32'h0);
        transact(2'd2, 11'h010, 1'b0, 32'h0, 1'b0, rd, er, lat);
        check("ld_word_data", rd, 32'h11223344);
        check("ld_word_err", 32'(er), 32'd0);
        check("ld_word_lat", 32'(lat), 32'd6);
        ram_read(11'h010, rb); check("ram_010", 32'(rb), 32'h44);
        ram_read(11'h011, rb); check("ram_011", 32'(rb), 32'h33);
        ram_read(11'h012, rb); check("ram_012", 32'(rb), 32'h22);
        ram_read(11'h013, rb); check("ram_013", 32'(rb), 32'h11);

        transact(2'd1, 11'h012, 1'b0, 32'h0, 1'b1, rd, er, lat);
        check("ld_half_hi", rd, 32'h00001122);
        check("ld_half_lat", 32'(lat), 32'd4);

        // 2: byte 0x80 at 0x013, signed and unsigned loads
        transact(2'd0, 11'h013, 1'b1, 32'hFFFFFF80, 1'b0, rd, er, lat);
        check("st_byte_lat", 32'(lat), 32'd2);
`ifdef BLOCK_MEMORY_WORD_PORT_SIGN_EXTEND_EN
        exp_signed = 32'hFFFFFF80;
`else
        exp_signed = 32'h00000080;
`endif
        transact(2'd0, 11'h013, 1'b0, 32'h0, 1'b0, rd, er, lat);
        check("ld_byte_signed", rd, exp_signed);
        check("ld_byte_lat", 32'(lat), 32'd3);
        transact(2'd0, 11'h013, 1'b0, 32'h0, 1'b1, rd, er, lat);
        check("ld_byte_unsigned", rd, 32'h00000080);
        transact(2'd2, 11'h010, 1'b0, 32'h0, 1'b0, rd, er, lat);
        check("ld_word_after_byte", rd, 32'h80223344);

        // 3: misaligned half and illegal size
        we_seen = 1'b0;
        transact(2'd1, 11'h011, 1'b1, 32'h0000DEAD, 1'b0, rd, er, lat);
        check("mis_half_err", 32'(er), 32'd1);
        check("mis_half_data", rd, 32'h0);
        check("mis_half_lat", 32'(lat), 32'd1);
        check("mis_half_no_we", 32'(we_seen), 32'd0);
        transact(2'd3, 11'h010, 1'b0, 32'h0, 1'b0, rd, er, lat);
        check("illegal_size_err", 32'(er), 32'd1);
        check("illegal_size_data", rd, 32'h0);
        check("illegal_no_we", 32'(we_seen), 32'd0);
        ram_read(11'h011, rb); check("ram_011_after_err", 32'(rb), 32'h33);

        // 4: response held under back-pressure
        resp_ready = 1'b0;
        transact(2'd2, 11'h010, 1'b0, 32'h0, 1'b0, rd, er, lat);
        check("bp_first_data", rd, 32'h80223344);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_data", resp_read_data, 32'h80223344);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;

        // 5: reset during the second byte of a word store
        transact(2'd2, 11'h020, 1'b1, 32'h55667788, 1'b0, rd, er, lat);
        @(posedge clk); #1;
        req_size = 2'd2; req_address = 11'h020; req_write = 1'b1;
        req_write_data = 32'hAABBCCDD; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid_we", 32'(mem_write_enable), 32'd0);
        rv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) rv_seen = 1'b1;
        end
        check("rst_mid_no_resp", 32'(rv_seen), 32'd0);
        ram_read(11'h020, rb); check("ram_020", 32'(rb), 32'hDD);
        ram_read(11'h021, rb); check("ram_021", 32'(rb), 32'hCC);
        ram_read(11'h022, rb); check("ram_022", 32'(rb), 32'h66);
        ram_read(11'h023, rb); check("ram_023", 32'(rb), 32'h55);

        // 6: top-of-memory half store, word load
        transact(2'd2, 11'h7FC, 1'b1, 32'h12345678, 1'b0, rd, er, lat);
        transact(2'd1, 11'h7FE, 1'b1, 32'h0000BEEF, 1'b0, rd, er, lat);
        check("st_half_top_err", 32'(er), 32'd0);
        check("st_half_top_lat", 32'(lat), 32'd3);
        transact(2'd2, 11'h7FC, 1'b0, 32'h0, 1'b0, rd, er, lat);
        check("ld_word_top", rd, 32'hBEEF5678);
        transact(2'd1, 11'h7FE, 1'b0, 32'h0, 1'b1, rd, er, lat);
        check("ld_half_top", rd, 32'h0000BEEF);
        ram_read(11'h020, rb); check("ram_020_no_wrap", 32'(rb), 32'hDD);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
